tlc_light_sequencer: RTL and testbench

Phase sequencer for the highway/farm-road traffic light controller. It sits directly downstream of the interval timer. It consumes the timer's green-interval and yellow-interval expiry pulses plus the farm-road car sensor, and drives both light heads. It issues a restart request back to the timer on every phase change and counts completed farm-road phases for status readout.

---
 rtl/tlc_pkg.sv | 43 ++++
 rtl/tlc_light_sequencer_if.sv | 24 ++
 rtl/tlc_clear_cnt.sv | 30 +++
 rtl/tlc_light_sequencer.sv | 114 +++++++++++
 tb/tb_tlc_light_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic light controller.
// Light encoding, phase/state codes and all-red clearance bounds.
package tlc_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam int unsigned ALL_RED_MIN = 1;
  localparam int unsigned ALL_RED_MAX = 15;
  localparam int unsigned CLR_W       = 4;
  localparam int unsigned PHASE_W     = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_HG  = 3'd0,
    PH_HY  = 3'd1,
    PH_FG  = 3'd2,
    PH_FY  = 3'd3,
    PH_AR1 = 3'd4,
    PH_AR2 = 3'd5
  } phase_e;

  typedef struct packed {
    logic [1:0] hwy;
    logic [1:0] farm;
  } heads_t;

  // Light heads shown while in a given phase; clearance phases are all-red.
  function automatic heads_t heads_of(input phase_e ph);
    heads_t h;
    h.hwy  = RED;
    h.farm = RED;
    case (ph)
      PH_HG:   h.hwy  = GREEN;
      PH_HY:   h.hwy  = YELLOW;
      PH_FG:   h.farm = GREEN;
      PH_FY:   h.farm = YELLOW;
      default: ;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tlc_light_sequencer_if.sv
// Timer, sensor and light-head signals of the phase sequencer.
// slave: the sequencer; master: the timer/sensor/head side.
interface tlc_light_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             car_detected;
  logic             long_to;
  logic             short_to;
  logic             tmr_restart;
  logic [1:0]       hwy_light;
  logic [1:0]       farm_light;
  logic [2:0]       phase;
  logic [CNT_W-1:0] farm_cycles;

  modport slave (
    input  car_detected, long_to, short_to,
    output tmr_restart, hwy_light, farm_light, phase, farm_cycles
  );

  modport master (
    output car_detected, long_to, short_to,
    input  tmr_restart, hwy_light, farm_light, phase, farm_cycles
  );
endinterface

// File: rtl/tlc_clear_cnt.sv
// All-red clearance down-counter: load a length, done is high during the
// last cycle of the interval.
module tlc_clear_cnt
  import tlc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CLR_W-1:0] load_val,
  output logic             done
);

  logic [CLR_W-1:0] cnt;

  // done is registered: it rises when the count steps down to one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      done <= (load_val == CLR_W'(1));
    end else if (en) begin
      if (cnt != '0) cnt <= cnt - CLR_W'(1);
      done <= (cnt == CLR_W'(2));
    end
  end

endmodule

// File: rtl/tlc_light_sequencer.sv
// Highway/farm-road phase sequencer driven by the interval timer pulses.
// Optional all-red clearance phases enabled by macro TLC_ALL_RED_EN.
module tlc_light_sequencer
  import tlc_pkg::*;
#(
  parameter int unsigned ALL_RED_CYC = 3,
  parameter int unsigned CNT_W       = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  tlc_light_sequencer_if.slave bus
);

  if (ALL_RED_CYC < ALL_RED_MIN || ALL_RED_CYC > ALL_RED_MAX) begin : g_bad_cfg
    $error("tlc_light_sequencer: ALL_RED_CYC out of range");
  end

  phase_e state;
  phase_e state_nxt;
  logic   restart_nxt;
  logic   farm_inc_c;
  heads_t heads_nxt;

`ifdef TLC_ALL_RED_EN
  logic clr_load_c;
  logic clr_done;

  tlc_clear_cnt u_clear_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (clr_load_c),
    .en       (state == PH_AR1 || state == PH_AR2),
    .load_val (CLR_W'(ALL_RED_CYC)),
    .done     (clr_done)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PH_HG;
    else        state <= state_nxt;
  end

  // Next phase; every pulse seen during the restart cycle is stale.
  always_comb begin
    state_nxt   = state;
    restart_nxt = 1'b0;
    farm_inc_c  = 1'b0;
`ifdef TLC_ALL_RED_EN
    clr_load_c  = 1'b0;
`endif
    if (!bus.tmr_restart) begin
      case (state)
        PH_HG: if (bus.long_to && bus.car_detected) begin
          state_nxt   = PH_HY;
          restart_nxt = 1'b1;
        end
        PH_HY: if (bus.short_to) begin
`ifdef TLC_ALL_RED_EN
          state_nxt   = PH_AR1;
          clr_load_c  = 1'b1;
`else
          state_nxt   = PH_FG;
          restart_nxt = 1'b1;
`endif
        end
        PH_FG: if (bus.long_to || !bus.car_detected) begin
          state_nxt   = PH_FY;
          restart_nxt = 1'b1;
        end
        PH_FY: if (bus.short_to) begin
`ifdef TLC_ALL_RED_EN
          state_nxt   = PH_AR2;
          clr_load_c  = 1'b1;
`else
          state_nxt   = PH_HG;
          restart_nxt = 1'b1;
          farm_inc_c  = 1'b1;
`endif
        end
`ifdef TLC_ALL_RED_EN
        PH_AR1: if (clr_done) begin
          state_nxt   = PH_FG;
          restart_nxt = 1'b1;
        end
        PH_AR2: if (clr_done) begin
          state_nxt   = PH_HG;
          restart_nxt = 1'b1;
          farm_inc_c  = 1'b1;
        end
`endif
        default: state_nxt = PH_HG;
      endcase
    end
    heads_nxt = heads_of(state_nxt);
  end

  // Registered outputs, all updated together with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tmr_restart <= 1'b0;
      bus.hwy_light   <= GREEN;
      bus.farm_light  <= RED;
      bus.farm_cycles <= '0;
    end else begin
      bus.tmr_restart <= restart_nxt;
      bus.hwy_light   <= heads_nxt.hwy;
      bus.farm_light  <= heads_nxt.farm;
      if (farm_inc_c) bus.farm_cycles <= bus.farm_cycles + CNT_W'(1);
    end
  end

  assign bus.phase = state;

endmodule

// File: tb/tb_tlc_light_sequencer.sv
// Directed self-checking bench for tlc_light_sequencer.
// Extra all-red checks are compiled in when TLC_ALL_RED_EN is defined.
module tb_tlc_light_sequencer;
  import tlc_pkg::*;

  localparam int unsigned CNT_W = 8;

`ifdef TLC_ALL_RED_EN
  localparam int AFTER_HY  = 4;
  localparam int AFTER_FY  = 5;
  localparam int RST_CLEAR = 0;
`else
  localparam int AFTER_HY  = 2;
  localparam int AFTER_FY  = 0;
  localparam int RST_CLEAR = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  tlc_light_sequencer_if #(.CNT_W(CNT_W)) bus ();

  tlc_light_sequencer #(.ALL_RED_CYC(3), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_long();
    bus.long_to = 1'b1;
    step();
    bus.long_to = 1'b0;
  endtask

  task automatic pulse_short();
    bus.short_to = 1'b1;
    step();
    bus.short_to = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int ph, input int hwy, input int farm,
                         input int rst);
    chk({tag, ".phase"}, 32'(bus.phase), 32'(ph));
    chk({tag, ".hwy"}, 32'(bus.hwy_light), 32'(hwy));
    chk({tag, ".farm"}, 32'(bus.farm_light), 32'(farm));
    chk({tag, ".restart"}, 32'(bus.tmr_restart), 32'(rst));
  endtask

  task automatic wait_phase(input string tag, input int ph, input int max_cyc);
    int n = 0;
    while (32'(bus.phase) != 32'(ph) && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.phase), 32'(ph));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_restart;
    logic saw_move;

    rst_n            = 1'b0;
    bus.car_detected = 1'b0;
    bus.long_to      = 1'b0;
    bus.short_to     = 1'b0;
    step(2);
    chk_out("reset", 0, 2, 0, 0);
    chk("reset.farm_cycles", 32'(bus.farm_cycles), 0);
    rst_n = 1'b1;
    step();

    // No car: long_to pulses must never leave HG.
    saw_restart = 1'b0;
    saw_move    = 1'b0;
    for (int c = 0; c < 100; c++) begin
      bus.long_to = (c % 30 == 29);
      step();
      bus.long_to = 1'b0;
      if (bus.tmr_restart !== 1'b0) saw_restart = 1'b1;
      if (bus.phase !== 3'd0 || bus.hwy_light !== 2'b10) saw_move = 1'b1;
    end
    chk("nocar.restart_seen", 32'(saw_restart), 0);
    chk("nocar.left_hg", 32'(saw_move), 0);
    chk_out("nocar.end", 0, 2, 0, 0);

    // Car waiting: HG -> HY on long_to, then HY -> FG on short_to.
    bus.car_detected = 1'b1;
    step(9);
    pulse_long();
    chk_out("hg_hy", 1, 1, 0, 1);
    step(4);
    chk_out("hy_hold", 1, 1, 0, 0);
    pulse_short();
    chk("hy_exit.phase", 32'(bus.phase), 32'(AFTER_HY));
    chk("hy_exit.restart", 32'(bus.tmr_restart), 32'(RST_CLEAR));
    wait_phase("to_fg", 2, 10);
    chk_out("fg_entry", 2, 0, 2, 1);
    step();

    // FG ignores short_to, releases early when the car leaves.
    pulse_short();
    chk_out("fg_ignore_short", 2, 0, 2, 0);
    bus.car_detected = 1'b0;
    step();
    chk_out("fg_empty", 3, 0, 1, 1);
    chk("fy.farm_cycles", 32'(bus.farm_cycles), 0);
    step();
    pulse_short();
    chk("fy_exit.phase", 32'(bus.phase), 32'(AFTER_FY));
    wait_phase("to_hg", 0, 10);
    chk_out("hg_entry", 0, 2, 0, 1);
    chk("hg_entry.farm_cycles", 32'(bus.farm_cycles), 1);
    step();

    // Simultaneous pulses: stale in the restart cycle, single step after.
    bus.car_detected = 1'b1;
    pulse_long();
    chk_out("stale.hg_hy", 1, 1, 0, 1);
    bus.long_to  = 1'b1;
    bus.short_to = 1'b1;
    step();
    chk_out("stale.ignored", 1, 1, 0, 0);
    step();
    bus.long_to  = 1'b0;
    bus.short_to = 1'b0;
    chk("both.phase", 32'(bus.phase), 32'(AFTER_HY));
    wait_phase("both.to_fg", 2, 10);
    step();
    chk_out("both.fg_hold", 2, 0, 2, 0);

    // Asynchronous reset in FG.
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 2, 0, 0);
    chk("async_rst.farm_cycles", 32'(bus.farm_cycles), 0);
    step();
    rst_n = 1'b1;
    step();
    chk_out("post_rst", 0, 2, 0, 0);

    // HY and FY ignore long_to.
    pulse_long();
    step();
    pulse_long();
    chk_out("hy_ignore_long", 1, 1, 0, 0);
    pulse_short();
    wait_phase("ign.to_fg", 2, 10);
    step();
    pulse_long();
    chk_out("fg_long", 3, 0, 1, 1);
    step();
    pulse_long();
    chk_out("fy_ignore_long", 3, 0, 1, 0);

`ifdef TLC_ALL_RED_EN
    // All-red clearance lasts exactly three cycles, no restart on entry.
    pulse_short();
    chk_out("ar2.c1", 5, 0, 0, 0);
    step();
    chk_out("ar2.c2", 5, 0, 0, 0);
    step();
    chk_out("ar2.c3", 5, 0, 0, 0);
    chk("ar2.farm_cycles", 32'(bus.farm_cycles), 0);
    step();
    chk_out("ar2.exit", 0, 2, 0, 1);
    chk("ar2.exit.farm_cycles", 32'(bus.farm_cycles), 1);
    step();
    pulse_long();
    step();
    pulse_short();
    chk_out("ar1.c1", 4, 0, 0, 0);
    pulse_long();
    chk_out("ar1.c2_ignore", 4, 0, 0, 0);
    step();
    chk_out("ar1.c3", 4, 0, 0, 0);
    step();
    chk_out("ar1.exit", 2, 0, 2, 1);
`endif

    // Counter wrap over 2^CNT_W farm phases from reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < (1 << CNT_W); i++) begin
      pulse_long();
      step();
      pulse_short();
      wait_phase("wrap.fg", 2, 10);
      step();
      pulse_long();
      step();
      pulse_short();
      wait_phase("wrap.hg", 0, 10);
      step();
      if (i == (1 << CNT_W) - 2) chk("wrap.max", 32'(bus.farm_cycles), 32'((1 << CNT_W) - 1));
    end
    chk("wrap.zero", 32'(bus.farm_cycles), 0);
    chk_out("wrap.end", 0, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
